// File: rtl/vga_frame_monitor.sv
// Passive VGA stream checker: measures visible line length and line count per
// frame, accumulates a rotate-add checksum and reports status on each frame close.
module vga_frame_monitor #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        vga_clock,
    input  logic        hsync,
    input  logic        vsync,
    input  logic        blank,
    input  logic [23:0] rgb,
    output logic        frame_done,
    output logic        frame_ok,
    output logic        err_hlen,
    output logic        err_vlen,
    output logic [31:0] checksum,
    output logic [15:0] frame_count
);

    typedef enum logic {SYNC = 1'b0, FRAME = 1'b1} state_t;

    localparam logic [10:0] H_ACT_W = 11'(H_ACTIVE);
    localparam logic [9:0]  V_ACT_W = 10'(V_ACTIVE);

    state_t      state_r, state_s;
    logic        blank_q_r, vsync_q_r;
    logic [10:0] pix_r, pix_s;
    logic [9:0]  line_r, line_s;
    logic [31:0] acc_r, acc_s;
    logic        hl_r, hl_s;
    logic        close_s;
    logic        smp_s, vfall_s, bfall_s;
    logic        vlen_bad_s;
    logic        unused_hsync_s;

    // hsync is carried by the stream but not measured
    assign unused_hsync_s = hsync;

    assign smp_s      = ~vga_clock;
    assign vfall_s    = vsync_q_r & ~vsync;
    assign bfall_s    = blank_q_r & ~blank;
    assign vlen_bad_s = (line_s != V_ACT_W);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= SYNC;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state: any sampled vsync fall puts us in (or keeps us in) FRAME
    always_comb begin
        state_s = state_r;
        case (state_r)
            SYNC:    state_s = (smp_s && vfall_s) ? FRAME : SYNC;
            FRAME:   state_s = FRAME;
            default: state_s = SYNC;
        endcase
    end

    // Datapath next values; line finalisation precedes frame close in one sample
    always_comb begin
        pix_s   = pix_r;
        line_s  = line_r;
        acc_s   = acc_r;
        hl_s    = hl_r;
        close_s = 1'b0;
        if (smp_s && (state_r == FRAME)) begin
            if (blank) begin
                pix_s = (pix_r == 11'h7FF) ? pix_r : pix_r + 11'd1;
                acc_s = {acc_r[30:0], acc_r[31]} + {8'h00, rgb};
            end else begin
                pix_s = pix_r;
            end
            if (bfall_s) begin
                hl_s   = hl_s | (pix_s != H_ACT_W);
                line_s = (line_s == 10'h3FF) ? line_s : line_s + 10'd1;
                pix_s  = 11'd0;
            end else begin
                line_s = line_r;
            end
            // A line cut short by vsync still counts, but is always a length error
            if (vfall_s) begin
                if (pix_s != 11'd0) begin
                    hl_s   = 1'b1;
                    line_s = (line_s == 10'h3FF) ? line_s : line_s + 10'd1;
                end else begin
                    hl_s = hl_s;
                end
                close_s = 1'b1;
            end else begin
                close_s = 1'b0;
            end
        end else if (smp_s && vfall_s) begin
            pix_s  = 11'd0;
            line_s = 10'd0;
            acc_s  = 32'd0;
            hl_s   = 1'b0;
        end else begin
            close_s = 1'b0;
        end
    end

    // Sample history, accumulators and registered frame report
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            blank_q_r   <= 1'b0;
            vsync_q_r   <= 1'b1;
            pix_r       <= 11'd0;
            line_r      <= 10'd0;
            acc_r       <= 32'd0;
            hl_r        <= 1'b0;
            frame_done  <= 1'b0;
            frame_ok    <= 1'b0;
            err_hlen    <= 1'b0;
            err_vlen    <= 1'b0;
            checksum    <= 32'd0;
            frame_count <= 16'd0;
        end else begin
            frame_done <= close_s;
            if (smp_s) begin
                blank_q_r <= blank;
                vsync_q_r <= vsync;
            end else begin
                blank_q_r <= blank_q_r;
                vsync_q_r <= vsync_q_r;
            end
            if (close_s) begin
                pix_r       <= 11'd0;
                line_r      <= 10'd0;
                acc_r       <= 32'd0;
                hl_r        <= 1'b0;
                checksum    <= acc_s;
                err_hlen    <= hl_s;
                err_vlen    <= vlen_bad_s;
                frame_ok    <= ~(hl_s | vlen_bad_s);
                frame_count <= frame_count + 16'd1;
            end else begin
                pix_r  <= pix_s;
                line_r <= line_s;
                acc_r  <= acc_s;
                hl_r   <= hl_s;
            end
        end
    end

endmodule

// File: doc/vga_frame_monitor.md
# vga_frame_monitor

Passive checker downstream of the VGA timing/pattern source (`vga_test`). It samples the outgoing `hsync`/`vsync`/`blank`/`rgb` stream once per pixel and measures the active line length and line count of each frame. It also accumulates a per-frame rotate-add checksum of the visible pixels and reports a one-cycle `frame_done` pulse with the frame status. Benches use it to compare frames, and the FPGA build uses it as a hardware self-test.

## Interface
- `H_ACTIVE`, default 640: required visible pixels per line.
- `V_ACTIVE`, default 480: required visible lines per frame.
- `clk`  input  1  system clock; the only clock.
- `reset`  input  1  asynchronous, active-low reset.
- `vga_clock`  input  1  pixel clock from the source, toggling at clk/2; used as a data qualifier only, never as a clock.
- `hsync`  input  1  horizontal sync, active-low; passed through, not checked.
- `vsync`  input  1  vertical sync, active-low.
- `blank`  input  1  1 = visible pixel, 0 = blanking.
- `rgb`  input  24  pixel data, {R,G,B}.
- `frame_done`  output  1  one-clk pulse when a frame closes.
- `frame_ok`  output  1  status of the last closed frame.
- `err_hlen`  output  1  last closed frame had at least one line with visible length ≠ H_ACTIVE.
- `err_vlen`  output  1  last closed frame had a line count ≠ V_ACTIVE.
- `checksum`  output  32  checksum of the last closed frame.
- `frame_count`  output  16  number of closed frames; wraps at 2^16.

## Operation
- Sample strobe: `smp = ~vga_clock`, evaluated at each `posedge clk`. Inputs are used only on `smp` cycles.
- Registered on each sample: `blank_q` and `vsync_q`.
  - Frame boundary event `vfall = vsync_q & ~vsync`.
  - End-of-line event `bfall = blank_q & ~blank`.
- FSM with two states:
  - SYNC (reset state): ignores pixels. On `vfall`, clears the accumulators and goes to FRAME. Does not pulse `frame_done`.
  - FRAME, on a sample with `blank=1`:
    - `pix_cnt` (11 bit) increments, saturating at 2047.
    - `acc = {acc[30:0],acc[31]} + {8'h0,rgb}`, mod 2^32.
  - FRAME, on `bfall`:
    - if `pix_cnt != H_ACTIVE`, set sticky `hl_err`;
    - `line_cnt` (10 bit) increments, saturating at 1023;
    - `pix_cnt` clears to 0.
  - FRAME, on `vfall`, close the frame and stay in FRAME:
    - `checksum <= acc`;
    - `err_hlen <= hl_err`;
    - `err_vlen <= (line_cnt != V_ACTIVE)`;
    - `frame_ok <= ~(both)`;
    - `frame_count++`;
    - clear `acc`, `pix_cnt`, `line_cnt`, `hl_err`;
    - pulse `frame_done`.
- Truncated line: if `vfall` arrives while `pix_cnt != 0`, the partial line counts as one line and sets `err_hlen`. The close then uses those updated values.
- Same sample with `blank=1` and `vfall`: the pixel is accumulated into the closing frame, and the partial-line rule above applies.
- Same sample with `bfall` and `vfall`: the line is finalised first, then the frame closes.

## Timing
- `frame_done` is high for exactly one clk, in the cycle after the `posedge` that registered `vfall`. `checksum`, `err_*`, `frame_ok` and `frame_count` are valid from that same cycle and hold until the next close.
- Latency from `vsync` falling (first sample) to `frame_done` is 1 clk.
- Reset, asynchronous and active-low: state = SYNC.
  - Outputs: `frame_done=0`, `frame_ok=0`, `err_hlen=0`, `err_vlen=0`, `checksum=0`, `frame_count=0`.
  - Internal: `blank_q=0`, `vsync_q=1`, all counters 0.
- Reset asserted mid-frame discards the partial frame; the first frame after reset is never reported.
- Non-sample cycles (`vga_clock=1`) change no state except that `frame_done` returns to 0.

## Test plan
- Reset mid-stream: `reset=0` for 3 clk during active video -> all outputs 0. After release, no `frame_done` until two `vsync` falls have been seen.
- Nominal small frame (H_ACTIVE=4, V_ACTIVE=2), rgb=24'h000001 on every visible pixel, two full frames -> second `vsync` fall gives:
  - `frame_done` pulse;
  - `checksum=32'h000000FF`;
  - `frame_ok=1`, `err_hlen=0`, `err_vlen=0`, `frame_count=1`.
- Short line: one line of the frame has 3 visible pixels -> `err_hlen=1`, `err_vlen=0`, `frame_ok=0`.
- Missing line: a frame with 1 visible line (V_ACTIVE=2) -> `err_vlen=1`, `frame_ok=0`.
- Truncated line: `vsync` falls while `blank=1` after 2 pixels of line 2 -> line counted (`err_vlen=0`), `err_hlen=1`. The checksum includes those 2 pixels.
- Full 640x480 stream driven from `vga_test`, 3 frames -> `frame_done` pulses 2 times, each exactly 1 clk wide. `frame_ok=1`, `frame_count=2`, and the checksum is identical for both frames.
